// File: rtl/note_sequencer.sv
// note_sequencer: FIFO-ordered note scheduler between the PS/2 decoder and
// the buzzer path. Each queued key code rings for NOTE_CYCLES clocks and is
// followed by GAP_CYCLES clocks of silence.
// Optional feature macro: NOTE_SEQ_OVERWRITE_EN -- a push to a full queue
// (with no same-cycle pop) evicts the oldest entry instead of being discarded.
module note_sequencer #(
    parameter int DEPTH       = 8,
    parameter int NOTE_CYCLES = 50000,
    parameter int GAP_CYCLES  = 10000
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iKeyValid,
    input  logic [7:0]               iKeyCode,
    input  logic                     iStop,
    output logic [7:0]               oFreqType,
    output logic                     oRing,
    output logic                     oBusy,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oFull,
    output logic                     oDropped
);

    localparam int PW     = $clog2(DEPTH);
    localparam int MAXC   = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;
    localparam int ONE_I  = 1;
    localparam int NOTE_I = NOTE_CYCLES - 1;
    localparam int GAP_I  = GAP_CYCLES - 1;

    localparam logic [CW-1:0] C_NOTE_LOAD = NOTE_I[CW-1:0];
    localparam logic [CW-1:0] C_GAP_LOAD  = GAP_I[CW-1:0];
    localparam logic [CW-1:0] C_ONE       = ONE_I[CW-1:0];
    localparam logic [PW-1:0] P_ONE       = ONE_I[PW-1:0];
    localparam logic [PW:0]   N_ONE       = ONE_I[PW:0];
    localparam logic [PW:0]   N_DEPTH     = DEPTH[PW:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_timer;
    logic [CW-1:0] w_timer_next;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [PW:0]   w_count_next;

    logic [7:0]    r_freq;
    logic [7:0]    w_freq_next;
    logic          r_ring;
    logic          w_ring_next;
    logic          r_busy;
    logic          r_full;
    logic          r_dropped;

    logic [7:0]    w_head;
    logic          w_expired;
    logic          w_empty;
    logic          w_is_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_drop;
    logic          w_evict;
    logic          w_write;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_expired  = (r_timer == '0);
    assign w_empty    = (r_count == '0);
    assign w_is_full  = (r_count == N_DEPTH);

    // Zero codes mean "no note"; iStop discards any same-cycle push silently.
    assign w_push_req = iKeyValid && (iKeyCode != 8'd0) && !iStop;
    assign w_push_ok  = w_push_req && (!w_is_full || w_pop);
    assign w_drop     = w_push_req && w_is_full && !w_pop;
`ifdef NOTE_SEQ_OVERWRITE_EN
    assign w_evict    = w_drop;
`else
    assign w_evict    = 1'b0;
`endif
    assign w_write    = w_push_ok || w_evict;

    // Next-state, duration counter and registered-output next values.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_freq_next  = r_freq;
        w_ring_next  = r_ring;
        w_pop        = 1'b0;
        if (iStop) begin
            w_state_next = ST_IDLE;
            w_timer_next = '0;
            w_freq_next  = 8'd0;
            w_ring_next  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_freq_next = 8'd0;
                    w_ring_next = 1'b0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_PLAY;
                        w_timer_next = C_NOTE_LOAD;
                        w_freq_next  = w_head;
                        w_ring_next  = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_expired) begin
                        w_state_next = ST_GAP;
                        w_timer_next = C_GAP_LOAD;
                        w_freq_next  = 8'd0;
                        w_ring_next  = 1'b0;
                    end else begin
                        w_timer_next = r_timer - C_ONE;
                    end
                end
                ST_GAP: begin
                    if (w_expired) begin
                        if (!w_empty) begin
                            // Chain straight into the next note with no IDLE cycle.
                            w_pop        = 1'b1;
                            w_state_next = ST_PLAY;
                            w_timer_next = C_NOTE_LOAD;
                            w_freq_next  = w_head;
                            w_ring_next  = 1'b1;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_timer_next = '0;
                        end
                    end else begin
                        w_timer_next = r_timer - C_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_timer_next = '0;
                    w_freq_next  = 8'd0;
                    w_ring_next  = 1'b0;
                end
            endcase
        end
    end

    // Occupancy: +1 on push, -1 on pop, unchanged for both/neither or eviction.
    always_comb begin
        w_count_next = r_count;
        if (iStop) begin
            w_count_next = '0;
        end else if (w_push_ok && !w_pop) begin
            w_count_next = r_count + N_ONE;
        end else if (w_pop && !w_push_ok) begin
            w_count_next = r_count - N_ONE;
        end
    end

    // State, duration counter and all registered outputs.
    always_ff @(posedge iClk or posedge iReset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (iReset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_freq    <= 8'd0;
            r_ring    <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_freq    <= w_freq_next;
            r_ring    <= w_ring_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_dropped <= w_drop;
        end
    end

    // Queue pointers, occupancy and full flag; pointers wrap modulo DEPTH.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (iStop) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + P_ONE;
                end
                if (w_pop || w_evict) begin
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                end
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == N_DEPTH);
        end
    end

    // Queue storage; on eviction wr_ptr equals rd_ptr, so the oldest slot is overwritten.
    always_ff @(posedge iClk) begin
        // NOTE: storage has no reset; entries are only ever read behind a valid count.
        if (w_write) begin
            r_mem[r_wr_ptr] <= iKeyCode;
        end
    end

    assign oFreqType = r_freq;
    assign oRing     = r_ring;
    assign oBusy     = r_busy;
    assign oCount    = r_count;
    assign oFull     = r_full;
    assign oDropped  = r_dropped;

endmodule
